// File: rtl/vp_burst_read_responder.sv
// -----------------------------------------------------------------------------
// vp_burst_read_responder
//
// Memory-side responder for the video pipeline frame-buffer read port. It
// accepts single-word and fixed-length burst read requests, fetches the words
// from a synchronous on-chip memory and returns them with cellular-RAM-like
// timing: a power-up delay, an initial access latency and a one-cycle stall
// whenever a burst crosses into a new row.
//
// Optional build macro: VP_RESP_PATTERN_GEN_EN
//   When defined, the backing memory is bypassed (mem_rd/mem_addr held at 0,
//   mem_rdata ignored) and each returned word is a vertical-stripe pattern:
//   16'h8080 when bit 3 of the word address is set, otherwise 16'h1010.
//   Timing is identical in both builds.
//
// Ports:
//   clk         in   system clock, the only clock
//   reset       in   synchronous, active-high reset
//   req_access  in   request valid, sampled only while idle
//   rd          in   1 = read, 0 = write (rejected with wr_err)
//   burst       in   1 = BURST_LEN words, 0 = single word
//   addr        in   start word address
//   data        out  returned word, valid while data_ok = 1, held otherwise
//   op_begun    out  one-cycle pulse when a request is accepted
//   data_ok     out  one-cycle strobe per returned word
//   ctrlr_good  out  high once the power-up delay has elapsed
//   wr_err      out  one-cycle pulse when a write request is rejected
//   mem_addr    out  backing-memory word address
//   mem_rd      out  backing-memory read enable
//   mem_rdata   in   backing-memory data, valid the cycle after mem_rd
// -----------------------------------------------------------------------------
module vp_burst_read_responder #(
  parameter int INIT_CYCLES = 150,
  parameter int LATENCY     = 4,    // must be >= 2
  parameter int BURST_LEN   = 16,
  parameter int PAGE_WORDS  = 128,  // power of two, >= 2
  parameter int ADDR_W      = 23,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_access,
  input  logic              rd,
  input  logic              burst,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              op_begun,
  output logic              data_ok,
  output logic              ctrlr_good,
  output logic              wr_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int ICNT_W    = $clog2(INIT_CYCLES) + 1;
  localparam int LCNT_W    = $clog2(LATENCY) + 1;
  localparam int WCNT_W    = $clog2(BURST_LEN) + 1;
  localparam int PAGE_BITS = $clog2(PAGE_WORDS);

  // S_DONE is the cycle that shows the final pulse of an operation (last
  // data_ok, or op_begun/wr_err of a rejected write); S_RECOV follows it.
  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_LAT, S_XFER, S_DONE, S_RECOV
  } state_t;

  state_t            state_q;
  logic [ICNT_W-1:0] init_cnt_q;
  logic [LCNT_W-1:0] lat_cnt_q;
  logic [WCNT_W-1:0] word_cnt_q;    // words issued so far
  logic [WCNT_W-1:0] n_words_q;     // words to return for this request
  logic [ADDR_W-1:0] ptr_q;         // address of the next word to issue
  logic [ADDR_W-1:0] issue_addr_q;  // address of the word being fetched
  logic              issue_q;       // one fetch per returned word
  logic              stalled_q;     // row-crossing stall already taken
  logic              op_begun_q;
  logic              wr_err_q;
  logic              data_ok_q;
  logic              ctrlr_good_q;
  logic [DATA_W-1:0] data_q;
  logic              page_edge;

  // Next word starts a new row; word 0 is issued from S_LAT so never stalls.
  assign page_edge = (ptr_q[PAGE_BITS-1:0] == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_INIT;
      init_cnt_q   <= '0;
      lat_cnt_q    <= '0;
      word_cnt_q   <= '0;
      n_words_q    <= '0;
      ptr_q        <= '0;
      issue_addr_q <= '0;
      issue_q      <= 1'b0;
      stalled_q    <= 1'b0;
      op_begun_q   <= 1'b0;
      wr_err_q     <= 1'b0;
      data_ok_q    <= 1'b0;
      ctrlr_good_q <= 1'b0;
    end else begin
      op_begun_q <= 1'b0;
      wr_err_q   <= 1'b0;
      issue_q    <= 1'b0;
      // Each word is strobed the cycle after its fetch was issued.
      data_ok_q  <= issue_q;
      case (state_q)
        S_INIT: begin
          if (init_cnt_q == ICNT_W'(INIT_CYCLES - 1)) begin
            ctrlr_good_q <= 1'b1;
            state_q      <= S_IDLE;
          end else begin
            init_cnt_q <= init_cnt_q + ICNT_W'(1);
          end
        end
        S_IDLE: begin
          if (req_access) begin
            op_begun_q <= 1'b1;
            ptr_q      <= addr;
            n_words_q  <= burst ? WCNT_W'(BURST_LEN) : WCNT_W'(1);
            lat_cnt_q  <= '0;
            if (rd) begin
              state_q <= S_LAT;
            end else begin
              wr_err_q <= 1'b1;
              state_q  <= S_DONE;
            end
          end
        end
        S_LAT: begin
          // The first fetch leaves here so its strobe lands LATENCY cycles
          // after the op_begun cycle.
          if (lat_cnt_q == LCNT_W'(LATENCY - 2)) begin
            issue_q      <= 1'b1;
            issue_addr_q <= ptr_q;
            ptr_q        <= ptr_q + ADDR_W'(1);
            word_cnt_q   <= WCNT_W'(1);
            stalled_q    <= 1'b0;
            state_q      <= S_XFER;
          end else begin
            lat_cnt_q <= lat_cnt_q + LCNT_W'(1);
          end
        end
        S_XFER: begin
          if (word_cnt_q == n_words_q) begin
            state_q <= S_DONE;
          end else if (page_edge && !stalled_q) begin
            stalled_q <= 1'b1;
          end else begin
            issue_q      <= 1'b1;
            issue_addr_q <= ptr_q;
            ptr_q        <= ptr_q + ADDR_W'(1);  // wraps silently to 0
            word_cnt_q   <= word_cnt_q + WCNT_W'(1);
            stalled_q    <= 1'b0;
          end
        end
        S_DONE:  state_q <= S_RECOV;
        S_RECOV: state_q <= S_IDLE;
        default: state_q <= S_INIT;
      endcase
    end
  end

`ifdef VP_RESP_PATTERN_GEN_EN
  // Pattern word is registered on the same edge as its data_ok strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (issue_q) begin
      data_q <= issue_addr_q[3] ? DATA_W'(16'h8080) : DATA_W'(16'h1010);
    end
  end

  logic unused_mem_path;
  assign unused_mem_path = ^{mem_rdata, issue_addr_q};

  assign data     = data_q;
  assign mem_rd   = 1'b0;
  assign mem_addr = '0;
`else
  // The RAM's own output register supplies the word during the strobe
  // cycle; data_q captures it there so data holds between strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (data_ok_q) begin
      data_q <= mem_rdata;
    end
  end

  assign data     = data_ok_q ? mem_rdata : data_q;
  assign mem_rd   = issue_q;
  assign mem_addr = issue_addr_q;
`endif

  assign op_begun   = op_begun_q;
  assign data_ok    = data_ok_q;
  assign ctrlr_good = ctrlr_good_q;
  assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_vp_burst_read_responder.sv
// -----------------------------------------------------------------------------
// tb_vp_burst_read_responder
//
// Self-checking bench. A reference model derives, for each accepted request,
// the cycle and value of every returned word from the start address, burst
// length, latency and row size; the DUT outputs are compared cycle by cycle
// at the falling edge. The backing memory returns addr[15:0] one cycle after
// each read. Covers power-up delay, single/burst reads, row crossing,
// address wrap, rejected writes, back-to-back requests and mid-burst reset.
// -----------------------------------------------------------------------------
module tb_vp_burst_read_responder;

  localparam int INIT_CYCLES = 150;
  localparam int LATENCY     = 4;
  localparam int BURST_LEN   = 16;
  localparam int PAGE_WORDS  = 128;
  localparam int ADDR_W      = 23;
  localparam int DATA_W      = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_access;
  logic              rd;
  logic              burst;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              op_begun;
  logic              data_ok;
  logic              ctrlr_good;
  logic              wr_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata = '0;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          idle_cyc = 0;   // first cycle the model expects the DUT idle
  int          drive_cyc = 0;  // cycle in which the pending request was raised
  logic [15:0] last_word = '0; // value data must hold between strobes

  vp_burst_read_responder #(
    .INIT_CYCLES(INIT_CYCLES), .LATENCY(LATENCY), .BURST_LEN(BURST_LEN),
    .PAGE_WORDS(PAGE_WORDS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .reset(reset), .req_access(req_access), .rd(rd),
    .burst(burst), .addr(addr), .data(data), .op_begun(op_begun),
    .data_ok(data_ok), .ctrlr_good(ctrlr_good), .wr_err(wr_err),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous backing memory: word content is its own low address bits.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem_addr[15:0];
  end

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Called at a falling edge right after reset was sampled high. Releases
  // reset, raises a single read at 0x10 during the power-up delay and checks
  // that nothing is issued until ctrlr_good, which must rise INIT_CYCLES later.
  task automatic init_seq();
    int c0;
    bit seen;
    reset = 1'b0;
    c0    = cyc;
    seen  = 1'b0;
    for (int i = 1; i <= INIT_CYCLES + 20 && !seen; i++) begin
      @(negedge clk);
      if (i == 10) begin
        rd = 1'b1; burst = 1'b0; addr = 23'h10; req_access = 1'b1;
        drive_cyc = cyc;
      end
      if (ctrlr_good) seen = 1'b1;
      else check_val("init_quiet", {op_begun, data_ok, wr_err, mem_rd}, 4'b0);
    end
    if (!seen) check_val("init_timeout", 32'd0, 32'd1);
    else       check_val("init_len", cyc - c0, INIT_CYCLES);
    idle_cyc = cyc;
  endtask

  // One request. Model: word k at (a+k) mod 2^23, strobed LATENCY+k+stalls
  // cycles after op_begun, where a stall precedes each k>=1 landing on a row
  // start. RECOV follows the last pulse, then IDLE. Returns at the falling
  // edge of the RECOV cycle so the next call can chain back-to-back.
  task automatic run_txn(input bit r, input bit b, input logic [22:0] a,
                         input bit predriven, input bit abort5);
    int          t0, exp_ob, n, stalls, end_c, p, pm, waited;
    int          dok_cyc[$];
    logic [15:0] dok_word[$];
    logic [22:0] dok_addr[$];
    logic [22:0] ak;
    bit          got_ob, exp_dok, exp_mrd;

    if (!predriven) begin
      rd = r; burst = b; addr = a; req_access = 1'b1;
      drive_cyc = cyc;
    end
    exp_ob = ((drive_cyc > idle_cyc) ? drive_cyc : idle_cyc) + 1;
    got_ob = 1'b0;
    waited = 0;
    while (!got_ob && waited < 64) begin
      if (op_begun) got_ob = 1'b1;
      else begin @(negedge clk); waited++; end
    end
    if (!got_ob) begin
      check_val("op_begun_timeout", 32'd0, 32'd1);
      req_access = 1'b0;
      return;
    end
    t0 = cyc;
    check_val("op_begun_cycle", t0, exp_ob);
    // Later changes on the request inputs must be ignored.
    req_access = 1'b0;
    rd = 1'($urandom); burst = 1'($urandom); addr = 23'($urandom);

    n      = r ? (b ? BURST_LEN : 1) : 0;
    stalls = 0;
    for (int k = 0; k < n; k++) begin
      ak = 23'((int'(a) + k) % (1 << 23));
      if (k > 0 && (int'(ak) % PAGE_WORDS) == 0) stalls++;
      dok_cyc.push_back(t0 + LATENCY + k + stalls);
      dok_addr.push_back(ak);
`ifdef VP_RESP_PATTERN_GEN_EN
      dok_word.push_back(ak[3] ? 16'h8080 : 16'h1010);
`else
      dok_word.push_back(ak[15:0]);
`endif
    end
    end_c = (n > 0) ? dok_cyc[n-1] + 1 : t0 + 1;

    p  = 0;
    pm = 0;
    for (int c = t0; c <= end_c; c++) begin
      if (c != t0) @(negedge clk);
      exp_dok = (p < n) && (dok_cyc[p] == c);
      check_val("ctrlr_good", ctrlr_good, 1);
      check_val("op_begun", op_begun, (c == t0));
      check_val("wr_err", wr_err, (!r && c == t0));
      check_val("data_ok", data_ok, exp_dok);
      if (exp_dok) begin
        check_val("data", data, dok_word[p]);
        last_word = dok_word[p];
        p++;
      end else begin
        check_val("data_hold", data, last_word);
      end
`ifdef VP_RESP_PATTERN_GEN_EN
      exp_mrd = 1'b0;
      check_val("mem_addr_tied", mem_addr, 0);
`else
      exp_mrd = (pm < n) && (dok_cyc[pm] == c + 1);
`endif
      check_val("mem_rd", mem_rd, exp_mrd);
      if (exp_mrd) begin
        check_val("mem_addr", mem_addr, dok_addr[pm]);
        pm++;
      end
      if (abort5 && exp_dok && p == 5) begin
        reset = 1'b1;
        @(negedge clk);
        check_val("rst_ctrl", {data_ok, op_begun, ctrlr_good, wr_err, mem_rd}, 5'b0);
        check_val("rst_data", data, 0);
        check_val("rst_mem_addr", mem_addr, 0);
        last_word = '0;
        $display("txn rd=%0d burst=%0d addr=%06h reset after 5 words at cycle %0d",
                 r, b, a, cyc);
        init_seq();
        return;
      end
    end
    idle_cyc = end_c + 1;
    $display("txn rd=%0d burst=%0d addr=%06h words=%0d stalls=%0d op_begun_cycle=%0d",
             r, b, a, n, stalls, t0);
  endtask

  task automatic random_txn();
    logic [22:0] ra;
    int          sel;
    sel = $urandom_range(0, 3);
    case (sel)
      0:       ra = 23'($urandom);
      1:       ra = 23'(PAGE_WORDS * $urandom_range(1, 1000) - $urandom_range(0, 20));
      2:       ra = 23'(32'h7FFFFF - $urandom_range(0, 20));
      default: ra = 23'($urandom_range(0, 255));
    endcase
    repeat ($urandom_range(0, 2)) @(negedge clk);
    run_txn(($urandom_range(0, 4) != 0), 1'($urandom), ra, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; req_access = 1'b0; rd = 1'b0; burst = 1'b0; addr = '0;
    repeat (3) @(negedge clk);
    check_val("reset_ctrl", {data_ok, op_begun, ctrlr_good, wr_err, mem_rd}, 5'b0);
    check_val("reset_data", data, 0);
    check_val("reset_mem_addr", mem_addr, 0);
    init_seq();
    run_txn(1'b1, 1'b0, 23'h000010, 1'b1, 1'b0);  // request raised during init
    run_txn(1'b1, 1'b1, 23'h00007A, 1'b0, 1'b0);  // row crossing mid-burst
    run_txn(1'b1, 1'b1, 23'h7FFFF8, 1'b0, 1'b0);  // address wrap
    run_txn(1'b0, 1'b1, 23'h001234, 1'b0, 1'b0);  // rejected write
    run_txn(1'b1, 1'b1, 23'h000000, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    run_txn(1'b1, 1'b0, 23'h0000FF, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) random_txn();
    run_txn(1'b1, 1'b1, 23'h00007F, 1'b0, 1'b1);  // reset on 5th word
    run_txn(1'b1, 1'b0, 23'h000010, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) random_txn();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vp_burst_read_responder.md
Name: vp_burst_read_responder

Overview:
Memory-side responder for the video pipeline's frame-buffer read interface (req_access/rd/burst/addr in; op_begun/data_ok/ctrlr_good/data out).
- Accepts single-word and fixed-length burst read requests.
- Fetches words from a synchronous on-chip memory port and returns them with cellular-RAM-like timing: power-up delay, initial access latency, one-cycle row-crossing stall.
- Replaces the constant-tie-offs at the top level so the pipeline sees realistic controller timing in both simulation and hardware.

Parameters:
- INIT_CYCLES, 150: cycles after reset before ctrlr_good asserts.
- LATENCY, 4: cycles from the op_begun pulse to the first data_ok.
- BURST_LEN, 16: words returned when burst=1.
- PAGE_WORDS, 128: row size in words, power of two; crossing a row inserts one stall cycle.
- ADDR_W, 23: word address width.
- DATA_W, 16: data width.

Ports:
- clk, in, 1: system clock (100 MHz domain); the only clock.
- reset, in, 1: synchronous, active-high.
- req_access, in, 1: request valid, sampled in IDLE only.
- rd, in, 1: 1 = read; 0 = write (unsupported).
- burst, in, 1: 1 = BURST_LEN words; 0 = single word.
- addr, in, ADDR_W: start word address.
- data, out, DATA_W: read word, valid only while data_ok=1.
- op_begun, out, 1: one-cycle pulse when a request is accepted.
- data_ok, out, 1: one-cycle strobe per returned word.
- ctrlr_good, out, 1: controller initialised and ready.
- wr_err, out, 1: one-cycle pulse when a write request is rejected.
- mem_addr, out, ADDR_W: backing-memory word address.
- mem_rd, out, 1: backing-memory read enable.
- mem_rdata, in, DATA_W: backing-memory data, valid 1 cycle after mem_rd.

Behaviour:
- Reset: synchronous, active-high. At the next edge all outputs go to 0 (data, op_begun, data_ok, ctrlr_good, wr_err, mem_addr, mem_rd) and the FSM goes to INIT. Reset asserted mid-transfer aborts it; no further data_ok is issued and ctrlr_good drops.
- INIT: counts INIT_CYCLES. ctrlr_good is registered high on the cycle the count completes, then the FSM moves to IDLE. ctrlr_good stays high until reset. req_access is ignored in INIT.
- IDLE: if req_access=1 at edge T, latch addr, burst and rd; op_begun=1 during cycle T+1 only.
  - rd=1: go to LAT.
  - rd=0: wr_err=1 during T+1, go to RECOV; no data_ok.
- LAT: wait so that the first data_ok is high in cycle T+1+LATENCY. mem_rd/mem_addr are issued exactly one cycle before each data_ok.
- XFER: returns N words, N=BURST_LEN if burst else 1.
  - Word k is read from (start+k) mod 2^ADDR_W; the address wraps silently to 0.
  - For k>=1, if (start+k) mod PAGE_WORDS == 0, one stall cycle with data_ok=0 precedes that word.
  - Words are otherwise back-to-back. data is registered from mem_rdata in the same cycle data_ok=1 and holds its value between strobes.
- RECOV: one cycle after the last word (or after a rejected write); req_access is ignored. Then IDLE.
- A new request is accepted only in IDLE. If req_access is still high when the FSM re-enters IDLE, it is taken as a new back-to-back request. Changes to req_access, addr or burst during LAT/XFER have no effect.
- Word counter width: clog2(BURST_LEN)+1. Latency counter width: clog2(LATENCY)+1.

Optional Feature:
- Macro: VP_RESP_PATTERN_GEN_EN.
- Defined: the backing memory is bypassed. mem_rd stays 0, mem_addr stays 0, mem_rdata is ignored. data = 16'h8080 when word address bit 3 = 1, else 16'h1010 (vertical stripe test pattern). All timing is unchanged.
- Undefined: data comes from mem_rdata as specified above.

Test Plan:
- Reset released at cycle 0, req_access=1 held from cycle 10 → ctrlr_good=1 from cycle 150. No op_begun before then; first op_begun within 2 cycles after ctrlr_good.
- Single read at addr 0x000010, mem model returns addr[15:0] → op_begun at T+1, one data_ok at T+5 with data=16'h0010, RECOV, back in IDLE at T+7.
- Burst at 0x00007A → 16 data_ok strobes, data 0x007A..0x007F, one stall cycle, then 0x0080..0x0089. Span T+5..T+21; exactly one gap, at T+11.
- Burst at 0x7FFFF8 → words 0xFFF8..0xFFFF, stall, 0x0000..0x0007; mem_addr wraps to 0.
- Reset asserted on the 5th data_ok of a burst → next cycle all outputs 0, no further strobes. ctrlr_good low for 150 cycles, then normal service resumes.
- rd=0 request → op_begun and wr_err pulse together at T+1, zero data_ok, IDLE at T+3. With VP_RESP_PATTERN_GEN_EN, a burst at 0x000000 returns 8×16'h1010 then 8×16'h8080.
